alu_flag_branch: RTL and testbench

//  Consumer end of the ALU result/flag interface: accepts each ALU result with its carry/zero/msb/overflow

---
 rtl/alu_flag_branch.sv | 158 +++++++++++++++
 tb/tb_alu_flag_branch.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_flag_branch.sv
// Flag register commit and conditional branch resolve between ALU and fetch.
// Optional saturating branch statistics built when FLAG_STATS_EN is defined.
module alu_flag_branch #(
  parameter int PC_W         = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             res_valid,
  output logic             res_ready,
  input  logic             alu_carry,
  input  logic             alu_zero,
  input  logic             alu_msb,
  input  logic             alu_ovf,
  input  logic             set_flags,
  input  logic [3:0]       br_op,
  input  logic [PC_W-1:0]  br_target,
  output logic [3:0]       flags,
  output logic             redirect_valid,
  input  logic             redirect_ready,
  output logic [PC_W-1:0]  redirect_pc,
  output logic             flush,
  output logic             illegal_br,
  output logic [CNT_W-1:0] stat_taken,
  output logic [CNT_W-1:0] stat_ntaken
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REDIR,
    S_FLUSH
  } state_t;

  state_t          state_q, state_d;
  logic [3:0]      flags_q, flags_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            ill_q, ill_d;

  logic       accept;
  logic [3:0] new_f;
  logic [3:0] src;
  logic       taken;
  logic       is_cond;
  logic       illegal;

  assign accept = res_valid & res_ready;
  assign new_f  = {alu_carry, alu_zero,
                   alu_msb, alu_ovf};
  // bypass so a flag-setting op can branch on its own flags
  assign src    = set_flags ? new_f : flags_q;

  always_comb begin
    taken   = 1'b0;
    is_cond = 1'b0;
    illegal = 1'b0;
    case (br_op)
      4'b0000: ;
      4'b0001: taken = 1'b1;
      4'b0010: begin is_cond = 1'b1; taken =  src[2]; end
      4'b0011: begin is_cond = 1'b1; taken = ~src[2]; end
      4'b0100: begin is_cond = 1'b1; taken =  src[3]; end
      4'b0101: begin is_cond = 1'b1; taken = ~src[3]; end
      4'b0110: begin is_cond = 1'b1; taken =  src[1]; end
      4'b0111: begin is_cond = 1'b1; taken = ~src[1]; end
      4'b1000: begin is_cond = 1'b1; taken =  src[0]; end
      4'b1001: begin is_cond = 1'b1; taken = ~src[0]; end
      default: illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      flags_q <= '0;
      pc_q    <= '0;
      cnt_q   <= '0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      flags_q <= flags_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      ill_q   <= ill_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (accept && taken) state_d = S_REDIR;
      end
      S_REDIR: begin
        if (redirect_ready) begin
          state_d = S_FLUSH;
          cnt_d   = 4'(FLUSH_CYCLES - 1);
        end
      end
      S_FLUSH: begin
        if (cnt_q == 4'd0) state_d = S_IDLE;
        else cnt_d = cnt_q - 4'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    flags_d = flags_q;
    pc_d    = pc_q;
    if (accept && set_flags) flags_d = new_f;
    if (accept && taken) pc_d = br_target;
    ill_d = accept & illegal;
  end

  always_comb begin
    res_ready      = reset_n & (state_q == S_IDLE);
    redirect_valid = (state_q == S_REDIR);
    flush          = (state_q == S_FLUSH);
    redirect_pc    = pc_q;
    flags          = flags_q;
    illegal_br     = ill_q;
  end

`ifdef FLAG_STATS_EN
  logic [CNT_W-1:0] tk_q, tk_d;
  logic [CNT_W-1:0] nt_q, nt_d;
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tk_q <= '0;
      nt_q <= '0;
    end else begin
      tk_q <= tk_d;
      nt_q <= nt_d;
    end
  end

  always_comb begin
    tk_d = tk_q;
    nt_d = nt_q;
    if (accept && taken && (tk_q != '1))
      tk_d = tk_q + ONE;
    if (accept && is_cond && !taken && (nt_q != '1))
      nt_d = nt_q + ONE;
  end

  assign stat_taken  = tk_q;
  assign stat_ntaken = nt_q;
`else
  assign stat_taken  = '0;
  assign stat_ntaken = '0;
`endif

endmodule

// File: tb/tb_alu_flag_branch.sv
// Scoreboard bench for alu_flag_branch: directed cases plus random ops
// against a rule-table reference model.
module tb_alu_flag_branch;
  localparam int PC_W = 32;
  localparam int FC   = 2;
  localparam int CW   = 4;

  logic            clk;
  logic            reset_n;
  logic            res_valid;
  logic            res_ready;
  logic            alu_carry, alu_zero;
  logic            alu_msb, alu_ovf;
  logic            set_flags;
  logic [3:0]      br_op;
  logic [PC_W-1:0] br_target;
  logic [3:0]      flags;
  logic            redirect_valid;
  logic            redirect_ready;
  logic [PC_W-1:0] redirect_pc;
  logic            flush;
  logic            illegal_br;
  logic [CW-1:0]   stat_taken;
  logic [CW-1:0]   stat_ntaken;

  alu_flag_branch #(
    .PC_W(PC_W), .FLUSH_CYCLES(FC), .CNT_W(CW)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .res_valid(res_valid), .res_ready(res_ready),
    .alu_carry(alu_carry), .alu_zero(alu_zero),
    .alu_msb(alu_msb), .alu_ovf(alu_ovf),
    .set_flags(set_flags), .br_op(br_op),
    .br_target(br_target), .flags(flags),
    .redirect_valid(redirect_valid),
    .redirect_ready(redirect_ready),
    .redirect_pc(redirect_pc), .flush(flush),
    .illegal_br(illegal_br),
    .stat_taken(stat_taken),
    .stat_ntaken(stat_ntaken)
  );

  int checks = 0;
  int passes = 0;
  int cyc = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  bit rr_rand = 0;
  bit rr_rnd = 0;
  bit rr_man = 0;
  assign redirect_ready = rr_rand ? rr_rnd : rr_man;
  always @(posedge clk) begin
    #1;
    rr_rnd = 1'($urandom_range(0, 1));
  end

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h want %0h",
                  nm, act, exp);
  endtask

  // reference model: architectural flags + stats
  logic [3:0] mflags = '0;
  int mtaken = 0;
  int mntaken = 0;
  localparam int SAT = (1 << CW) - 1;

  typedef struct {
    logic [3:0] fl;
    bit         ill;
  } exp_t;
  exp_t            acc_q[$];
  logic [PC_W-1:0] pc_q[$];

  // f = {C,Z,N,V}
  function automatic bit rule(input logic [3:0] op,
                              input logic [3:0] f,
                              output bit ill,
                              output bit cnd);
    bit c, z, n, v;
    {c, z, n, v} = f;
    ill = (op >= 4'd10);
    cnd = (op >= 4'd2) && (op <= 4'd9);
    case (op)
      4'd1: return 1;
      4'd2: return z;
      4'd3: return !z;
      4'd4: return c;
      4'd5: return !c;
      4'd6: return n;
      4'd7: return !n;
      4'd8: return v;
      4'd9: return !v;
      default: return 0;
    endcase
  endfunction

  task automatic send(input logic [3:0] op,
                      input logic [3:0] fl,
                      input bit sf,
                      input logic [PC_W-1:0] tgt);
    int n = 0;
    bit t, ill, cnd;
    exp_t e;
    res_valid = 1'b1;
    {alu_carry, alu_zero, alu_msb, alu_ovf} = fl;
    set_flags = sf;
    br_op     = op;
    br_target = tgt;
    while (!res_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!res_ready) begin
      checks++;
      $display("FAIL accept_timeout: got ready=0 want 1");
      res_valid = 1'b0;
      return;
    end
    t = rule(op, sf ? fl : mflags, ill, cnd);
    if (sf) mflags = fl;
    e.fl  = mflags;
    e.ill = ill;
    acc_q.push_back(e);
    if (t) begin
      pc_q.push_back(tgt);
      if (mtaken < SAT) mtaken++;
    end else if (cnd) begin
      if (mntaken < SAT) mntaken++;
    end
    @(posedge clk);
    #1;
    res_valid = 1'b0;
  endtask

  always @(posedge clk) begin : mon
    bit a, hs;
    exp_t e;
    a  = res_valid && res_ready;
    hs = redirect_valid && redirect_ready;
    @(negedge clk);
    if (a) begin
      if (acc_q.size() == 0) begin
        checks++;
        $display("FAIL acc_q: got empty want entry");
      end else begin
        e = acc_q.pop_front();
        chk("flags", 64'(flags), 64'(e.fl));
        chk("illegal_br", 64'(illegal_br), 64'(e.ill));
      end
    end
    if (hs && pc_q.size() != 0) void'(pc_q.pop_front());
  end

  always @(negedge clk) begin
    if (reset_n && redirect_valid) begin
      if (pc_q.size() == 0) begin
        checks++;
        $display("FAIL redirect_spurious: got valid want idle");
      end else
        chk("redirect_pc", 64'(redirect_pc), 64'(pc_q[0]));
    end
  end

  int run = 0;
  always @(negedge clk) begin
    if (!reset_n) run = 0;
    else if (flush) run++;
    else if (run != 0) begin
      chk("flush_len", 64'(run), 64'(FC));
      chk("ready_after_flush", 64'(res_ready), 64'd1);
      run = 0;
    end
  end

  task automatic chk_stats(input string nm);
`ifdef FLAG_STATS_EN
    chk({nm, "_taken"}, 64'(stat_taken), 64'(mtaken));
    chk({nm, "_ntaken"}, 64'(stat_ntaken), 64'(mntaken));
`else
    chk({nm, "_taken"}, 64'(stat_taken), 64'd0);
    chk({nm, "_ntaken"}, 64'(stat_ntaken), 64'd0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    reset_n   = 1'b0;
    res_valid = 1'b0;
    {alu_carry, alu_zero, alu_msb, alu_ovf} = '0;
    set_flags = 1'b0;
    br_op     = '0;
    br_target = '0;
    #2;
    chk("rst_ready", 64'(res_ready), 64'd0);
    chk("rst_flags", 64'(flags), 64'd0);
    chk("rst_rvalid", 64'(redirect_valid), 64'd0);
    chk("rst_flush", 64'(flush), 64'd0);
    chk("rst_pc", 64'(redirect_pc), 64'd0);
    chk("rst_ill", 64'(illegal_br), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk("ready_post_rst", 64'(res_ready), 64'd1);

    // taken on bypassed Z, redirect held off
    send(4'b0010, 4'b0100, 1'b1, 32'h100);
    chk("t2_rvalid", 64'(redirect_valid), 64'd1);
    chk("t2_pc", 64'(redirect_pc), 64'h100);
    chk("t2_flags", 64'(flags), 64'b0100);
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("t3_hold", 64'(redirect_valid), 64'd1);
    end
    rr_man = 1'b1;
    @(posedge clk);
    #1;
    rr_man = 1'b0;
    chk("t3_rv_drop", 64'(redirect_valid), 64'd0);
    chk("t3_fl1", 64'(flush), 64'd1);
    @(posedge clk);
    #1;
    chk("t3_fl2", 64'(flush), 64'd1);
    @(posedge clk);
    #1;
    chk("t3_fl_end", 64'(flush), 64'd0);
    chk("t3_ready", 64'(res_ready), 64'd1);

    // not taken on stored Z, then back-to-back
    send(4'b0011, 4'b0000, 1'b0, 32'h200);
    chk("t4_flags", 64'(flags), 64'b0100);
    chk("t4_ready", 64'(res_ready), 64'd1);
    t0 = cyc;
    repeat (8)
      send(4'b0000, 4'($urandom), 1'($urandom),
           $urandom);
    chk("t4_b2b", 64'(cyc - t0), 64'd8);

    send(4'b1100, 4'b0000, 1'b0, 32'h300);
    chk("t5_ill", 64'(illegal_br), 64'd1);
    chk("t5_norv", 64'(redirect_valid), 64'd0);
    @(posedge clk);
    #1;
    chk("t5_ill_end", 64'(illegal_br), 64'd0);
    chk("t5_ready", 64'(res_ready), 64'd1);

    // reset while flushing
    rr_man = 1'b1;
    send(4'b0001, 4'b1011, 1'b1, 32'h400);
    @(posedge clk);
    #1;
    rr_man = 1'b0;
    chk("t1_in_flush", 64'(flush), 64'd1);
    #1;
    reset_n = 1'b0;
    mflags  = '0;
    mtaken  = 0;
    mntaken = 0;
    #1;
    chk("t1_flush", 64'(flush), 64'd0);
    chk("t1_rvalid", 64'(redirect_valid), 64'd0);
    chk("t1_flags", 64'(flags), 64'd0);
    chk("t1_ready", 64'(res_ready), 64'd0);
    chk_stats("t1_stat");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk("t1_ready_rel", 64'(res_ready), 64'd1);

    // statistics saturation
    rr_rand = 1;
    repeat (20) send(4'b0001, 4'b0000, 1'b0, $urandom);
    repeat (3) send(4'b0100, 4'b0000, 1'b1, $urandom);
    chk_stats("t6_stat");

    repeat (300)
      send(4'($urandom), 4'($urandom),
           1'($urandom), $urandom);

    rr_rand = 0;
    rr_man  = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("drain_pc", 64'(pc_q.size()), 64'd0);
    chk("drain_acc", 64'(acc_q.size()), 64'd0);
    chk("final_flags", 64'(flags), 64'(mflags));
    chk_stats("final_stat");
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
